data_mem_responder: RTL and testbench

Data-memory responder for the RV32 core's load/store path: the target end of the CPU's data-memory request interface. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. Stores update byte lanes; loads are sign- or zero-extended to 32 bits. A response is returned over a second valid/ready handshake. It replaces the zero-latency array behind the core's load/store unit, so the core's stall logic can be exercised.

---
 rtl/data_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, registered response.
// Define DMEM_BACKDOOR_EN to add a full-word backdoor write port (bd_we/bd_addr/bd_wdata).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_BACKDOOR_EN
  ,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx_s;
  logic              size_err_s;
  logic              range_err_s;
  logic              acc_err_s;
  logic              mem_we_s;
  logic [3:0]        wmask_s;
  logic [31:0]       wlane_s;
  logic [31:0]       rd_word_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       load_data_s;

  assign req_ready   = (state_q == ST_IDLE) && !reset;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

  assign idx_s       = addr_q[IDX_W+1:2];
  assign range_err_s = (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign acc_err_s   = size_err_s || range_err_s;
  assign rd_word_s   = mem_q[idx_s];
  assign byte_s      = rd_word_s[{addr_q[1:0], 3'b000} +: 8];
  assign half_s      = addr_q[1] ? rd_word_s[31:16] : rd_word_s[15:0];

  // Alignment check, store lane mask/data and load extension for the captured request
  always_comb begin
    size_err_s  = 1'b0;
    wmask_s     = 4'b0000;
    wlane_s     = wdata_q;
    load_data_s = rd_word_s;
    case (size_q)
      2'b00: begin
        size_err_s  = 1'b0;
        wmask_s     = 4'b0001 << addr_q[1:0];
        wlane_s     = {4{wdata_q[7:0]}};
        load_data_s = uns_q ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      end
      2'b01: begin
        size_err_s  = addr_q[0];
        wmask_s     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_s     = {2{wdata_q[15:0]}};
        load_data_s = uns_q ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      end
      2'b10: begin
        size_err_s  = (addr_q[1:0] != 2'b00);
        wmask_s     = 4'b1111;
        wlane_s     = wdata_q;
        load_data_s = rd_word_s;
      end
      default: begin
        size_err_s  = 1'b1;
        wmask_s     = 4'b0000;
        wlane_s     = wdata_q;
        load_data_s = 32'd0;
      end
    endcase
  end

  // Next-state and response logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we_s    = wr_q && !acc_err_s;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err_s;
          rsp_rdata_d = (acc_err_s || wr_q) ? 32'd0 : load_data_s;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory array (not reset); a backdoor write to the same word wins over a functional store
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      if (wmask_s[0]) mem_q[idx_s][7:0]   <= wlane_s[7:0];
      if (wmask_s[1]) mem_q[idx_s][15:8]  <= wlane_s[15:8];
      if (wmask_s[2]) mem_q[idx_s][23:16] <= wlane_s[23:16];
      if (wmask_s[3]) mem_q[idx_s][31:24] <= wlane_s[31:24];
    end
`ifdef DMEM_BACKDOOR_EN
    if (bd_we && (bd_addr < 32'(DEPTH_WORDS))) begin
      mem_q[bd_addr[IDX_W-1:0]] <= bd_wdata;
    end
`endif
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model checked every cycle, plus directed literal checks.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_BACKDOOR_EN
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [31:0] bd_wdata;
`endif

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
`ifdef DMEM_BACKDOOR_EN
    ,
    .bd_we        (bd_we),
    .bd_addr      (bd_addr),
    .bd_wdata     (bd_wdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: byte-addressed memory, response due WAITC+1 edges after acceptance
  logic [7:0]  mbytes [DEPTH*4];
  int          cyc = 0;
  bit          m_pend = 1'b0;
  bit          m_valid = 1'b0;
  int          m_resp_at = 0;
  logic        c_w;
  logic [31:0] c_a, c_d;
  logic [1:0]  c_sz;
  logic        c_u;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic u,
                              output logic [31:0] rd, output logic er);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    er = (sz == 2'd3) || ((a % 32'(nb)) != 32'd0) || ((a >> 2) >= 32'(DEPTH));
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mbytes[a + 32'(i)] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mbytes[a + 32'(i)];
        if (!u && nb == 1) v = {{24{v[7]}}, v[7:0]};
        else if (!u && nb == 2) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_pend  = 1'b0;
        m_valid = 1'b0;
      end else begin
        cyc++;
        if (m_valid) begin
          if (rsp_ready) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
          end
        end else if (m_pend) begin
          if (cyc == m_resp_at) begin
            model_access(c_w, c_a, c_d, c_sz, c_u, m_rdata, m_err);
            m_valid = 1'b1;
          end
        end else if (req_valid) begin
          c_w = req_write; c_a = req_addr; c_d = req_wdata; c_sz = req_size; c_u = req_unsigned;
          m_pend    = 1'b1;
          m_resp_at = cyc + WAITC + 1;
        end
`ifdef DMEM_BACKDOOR_EN
        if (bd_we && (bd_addr < 32'(DEPTH))) begin
          for (int i = 0; i < 4; i++) mbytes[bd_addr*4 + 32'(i)] = bd_wdata[8*i +: 8];
        end
`endif
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
      end else begin
        chk("req_ready", 32'(req_ready), 32'(!m_pend));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_err",   32'(rsp_err), 32'(m_err));
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = sz; req_unsigned = u;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_BEEF;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  task automatic expect_rsp(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic u, input int hold,
                            input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(w, a, d, sz, u, hold, rd, er, lat);
    chk({nm, "_rdata"},   rd, exp_rd);
    chk({nm, "_err"},     32'(er), 32'(exp_er));
    chk({nm, "_latency"}, 32'(lat), 32'(WAITC + 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b0;
`ifdef DMEM_BACKDOOR_EN
    bd_we = 1'b0; bd_addr = 32'd0; bd_wdata = 32'd0;
`endif
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    expect_rsp("t1_sw",  1'b1, 32'd16, 32'h0000_0001, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b0);
    expect_rsp("t1_lw",  1'b0, 32'd16, 32'd0,         2'b10, 1'b0, 0, 32'h0000_0001, 1'b0);

    expect_rsp("t2_sw",  1'b1, 32'd0, 32'h80FF_7F01, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b0);
    expect_rsp("t2_lb",  1'b0, 32'd3, 32'd0, 2'b00, 1'b0, 0, 32'hFFFF_FF80, 1'b0);
    expect_rsp("t2_lbu", 1'b0, 32'd3, 32'd0, 2'b00, 1'b1, 0, 32'h0000_0080, 1'b0);
    expect_rsp("t2_lh",  1'b0, 32'd2, 32'd0, 2'b01, 1'b0, 0, 32'hFFFF_80FF, 1'b0);
    expect_rsp("t2_lhu", 1'b0, 32'd2, 32'd0, 2'b01, 1'b1, 0, 32'h0000_80FF, 1'b0);
    expect_rsp("t2_lb0", 1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 0, 32'h0000_0001, 1'b0);
    expect_rsp("t2_lh0", 1'b0, 32'd0, 32'd0, 2'b01, 1'b0, 0, 32'h0000_7F01, 1'b0);

    expect_rsp("t3_sw",  1'b1, 32'd4, 32'hAABB_CCDD, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b0);
    expect_rsp("t3_sb",  1'b1, 32'd5, 32'h0000_0011, 2'b00, 1'b0, 0, 32'h0000_0000, 1'b0);
    expect_rsp("t3_lw",  1'b0, 32'd4, 32'd0,         2'b10, 1'b0, 0, 32'hAABB_11DD, 1'b0);

    expect_rsp("sh_sw",  1'b1, 32'd12, 32'h0102_0304, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b0);
    expect_rsp("sh_sh",  1'b1, 32'd14, 32'h5555_BEEF, 2'b01, 1'b0, 0, 32'h0000_0000, 1'b0);
    expect_rsp("sh_lw",  1'b0, 32'd12, 32'd0,         2'b10, 1'b0, 0, 32'hBEEF_0304, 1'b0);

    expect_rsp("t4_lw6",    1'b0, 32'd6,       32'd0, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b1);
    expect_rsp("t4_lh1",    1'b0, 32'd1,       32'd0, 2'b01, 1'b0, 0, 32'h0000_0000, 1'b1);
    expect_rsp("t4_sz3",    1'b0, 32'd0,       32'd0, 2'b11, 1'b0, 0, 32'h0000_0000, 1'b1);
    expect_rsp("t4_oob",    1'b0, 32'(DEPTH*4), 32'd0, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b1);
    expect_rsp("t4_sw_sz3", 1'b1, 32'd4, 32'hFFFF_FFFF, 2'b11, 1'b0, 0, 32'h0000_0000, 1'b1);
    expect_rsp("t4_sw_mis", 1'b1, 32'd6, 32'hFFFF_FFFF, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b1);
    expect_rsp("t4_lw4",    1'b0, 32'd4, 32'd0,         2'b10, 1'b0, 0, 32'hAABB_11DD, 1'b0);

    expect_rsp("t5_hold", 1'b0, 32'd16, 32'd0, 2'b10, 1'b0, 5, 32'h0000_0001, 1'b0);

    expect_rsp("t6_sw_old", 1'b1, 32'd8, 32'h0BAD_F00D, 2'b10, 1'b0, 0, 32'h0000_0000, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd8; req_wdata = 32'h1234_5678;
    req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    expect_rsp("t6_lw_old", 1'b0, 32'd8, 32'd0, 2'b10, 1'b0, 0, 32'h0BAD_F00D, 1'b0);

`ifdef DMEM_BACKDOOR_EN
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 32'd2; bd_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bd_addr = 32'(DEPTH); bd_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bd_we = 1'b0;
    expect_rsp("t6_lw_bd", 1'b0, 32'd8, 32'd0, 2'b10, 1'b0, 0, 32'hCAFE_F00D, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
